// File: rtl/imm_encoder.sv
// imm_encoder -- places a full-width immediate into the immediate fields of a
// pre-built RV32 instruction word and flags immediates that do not fit the
// selected format. Two-stage valid/ready pipeline: stage 1 registers the
// placed word and range-check result, stage 2 is the output register.
// Each output word carries the instruction-memory write address, which
// advances by one per output transfer.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake
//   base[31:0]          instruction with all non-immediate fields filled
//   imm[31:0]           immediate value
//   immsrc[2:0]         001 I, 010 U, 011 S, 100 B, 101 J, else none
//   out_valid/out_ready output handshake
//   instr[31:0]         encoded instruction
//   addr[ADDR_WIDTH-1:0] write address for instr
//   err                 immediate not representable (qualified by out_valid)
//   err_count[7:0]      saturating count of output transfers with err=1
//                       (present only when IMM_ENCODER_ERRCNT_EN is defined)
module imm_encoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           base,
  input  logic [31:0]           imm,
  input  logic [2:0]            immsrc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  err
`ifdef IMM_ENCODER_ERRCNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam int STAGES = 2;

  localparam logic [2:0] SRC_I = 3'b001;
  localparam logic [2:0] SRC_U = 3'b010;
  localparam logic [2:0] SRC_S = 3'b011;
  localparam logic [2:0] SRC_B = 3'b100;
  localparam logic [2:0] SRC_J = 3'b101;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_t;

  // vld_pipe[1] = stage-1 occupied, vld_pipe[STAGES] = output register occupied
  logic [STAGES:1] vld_pipe;
  enc_t            enc, s1_q, s2_q;
  logic            s2_ready;

  // True when imm[31:msb] are all equal, i.e. imm sign-extends from bit msb.
  function automatic logic sext_ok(input logic [31:0] v, input int msb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << msb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction

  // Field placement and range check. Out-of-range immediates are still
  // encoded from their truncated low bits so err is purely advisory.
  always_comb begin
    enc.instr = base;
    enc.err   = 1'b0;
    case (immsrc)
      SRC_I: begin
        enc.instr = {imm[11:0], base[19:0]};
        enc.err   = !sext_ok(imm, 11);
      end
      SRC_U: begin
        enc.instr = {imm[31:12], base[11:0]};
        enc.err   = |imm[11:0];
      end
      SRC_S: begin
        enc.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        enc.err   = !sext_ok(imm, 11);
      end
      SRC_B: begin
        enc.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        enc.err   = !sext_ok(imm, 12) || imm[0];
      end
      SRC_J: begin
        enc.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        enc.err   = !sext_ok(imm, 20) || imm[0];
      end
      default: begin
        enc.instr = base;
        enc.err   = 1'b0;
      end
    endcase
  end

  // Output register can load when empty or being drained this cycle;
  // stage 1 can load when empty or moving into the output register.
  assign s2_ready = !vld_pipe[2] || out_ready;
  assign in_ready = !vld_pipe[1] || s2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      addr     <= '0;
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= enc;
      end
      if (s2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s1_q;
      end
      if (vld_pipe[2] && out_ready) addr <= addr + ADDR_WIDTH'(1);
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign instr     = s2_q.instr;
  assign err       = s2_q.err;

`ifdef IMM_ENCODER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (vld_pipe[2] && out_ready && s2_q.err && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: reset state, every immediate format incl.
// range errors, backpressure ordering, address wrap and mid-flight reset.
module tb_imm_encoder;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0]   base, imm, instr;
  logic [2:0]    immsrc;
  logic [AW-1:0] addr;
`ifdef IMM_ENCODER_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] exp_addr;

  always #5 clk = ~clk;

  imm_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .imm(imm), .immsrc(immsrc),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .err(err)
`ifdef IMM_ENCODER_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One word through an idle pipeline with out_ready=1.
  task automatic one(input string tag, input logic [2:0] src, input logic [31:0] b,
                     input logic [31:0] i, input logic [31:0] e_instr, input logic e_err);
    @(negedge clk);
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; base = b; imm = i; immsrc = src;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " early"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, " instr"}, instr, e_instr);
    chk({tag, " err"}, {31'b0, err}, {31'b0, e_err});
    chk({tag, " addr"}, {24'b0, addr}, {24'b0, exp_addr});
    exp_addr++;
  endtask

  function automatic logic [31:0] bp_word(input int k);
    return 32'h13 | 32'(k << 7) | 32'((k + 1) << 20);
  endfunction

  initial begin
    int tx, rx, stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    base = '0; imm = '0; immsrc = '0; exp_addr = '0;

    // ---- reset state
    #12;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst addr", {24'b0, addr}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // ---- directed formats
    one("I neg1",  3'b001, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0);
    one("I range", 3'b001, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1);
    one("B 800",   3'b100, 32'h0000_0063, 32'h0000_0800, 32'h0000_00E3, 1'b0);
    one("B odd",   3'b100, 32'h0000_0063, 32'h0000_0801, 32'h0000_00E3, 1'b1);
    one("U ok",    3'b010, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0);
    one("U low",   3'b010, 32'h0000_0037, 32'h1234_5001, 32'h1234_5037, 1'b1);
    one("S m4",    3'b011, 32'h0000_2023, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0);
    one("J ffe",   3'b101, 32'h0000_006F, 32'h0000_0FFE, 32'h7FF0_006F, 1'b0);
    one("J range", 3'b101, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, 1'b1);
    one("none0",   3'b000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0);
    one("none7",   3'b111, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
`ifdef IMM_ENCODER_ERRCNT_EN
    chk("err_count", {24'b0, err_count}, 32'd4);
`endif

    // ---- backpressure: 4 back-to-back words, out_ready low 3 cycles
    tx = 0; rx = 0;
    immsrc = 3'b001;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      #1;
      if (cyc == 2) begin
        chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
        chk("bp hold valid", {31'b0, out_valid}, 32'd1);
        chk("bp hold instr", instr, bp_word(0));
        chk("bp hold addr", {24'b0, addr}, {24'b0, exp_addr});
      end
      if (out_valid && out_ready) begin
        chk("bp instr", instr, bp_word(rx));
        chk("bp addr", {24'b0, addr}, {24'b0, exp_addr});
        rx++; exp_addr++;
      end
      in_valid = (tx < 4);
      base = 32'h13 | 32'(tx << 7);
      imm  = 32'(tx + 1);
      if (in_valid && in_ready) tx++;
    end
    chk("bp count", 32'(rx), 32'd4);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // ---- address wrap: reset, then 2^AW+1 transfers
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tx = 0; rx = 0;
    immsrc = 3'b000; base = 32'h0000_0013;
    for (int cyc = 0; cyc < 600 && rx < 257; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (tx < 257);
      #1;
      if (out_valid) begin
        if (rx >= 255) chk($sformatf("wrap addr %0d", rx), {24'b0, addr}, 32'(rx % 256));
        else if (addr !== AW'(rx)) chk("stream addr", {24'b0, addr}, 32'(rx % 256));
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    chk("wrap count", 32'(rx), 32'd257);
    @(negedge clk); in_valid = 1'b0;

    // ---- reset with both stages full
    out_ready = 1'b0;
    base = 32'h0000_0013; imm = 32'h0000_0123; immsrc = 3'b001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (!in_ready) break;
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    chk("full in_ready", {31'b0, in_ready}, 32'd0);
    chk("full out_valid", {31'b0, out_valid}, 32'd1);
    #1; rst_n = 1'b0; #1;
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst addr", {24'b0, addr}, 32'd0);
    chk("mid rst instr", instr, 32'd0);
    chk("mid rst err", {31'b0, err}, 32'd0);
`ifdef IMM_ENCODER_ERRCNT_EN
    chk("mid rst err_count", {24'b0, err_count}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no stale", 32'(stale), 32'd0);
    chk("post rst in_ready", {31'b0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
